// File: rtl/y86_pipe_ctrl.sv
// Y-86 5-stage pipeline control: stall/bubble generation, CC gating, FLUSH/RUN/DRAIN/HALTED run-state FSM.
// Outputs are combinational from state + current inputs; optional perf counters under PIPE_PERF_CNT_EN.
module y86_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    input  logic [3:0] W_icode,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       W_bubble,
    output logic       set_cc,
    output logic [1:0] state,
    output logic       halted,
    output logic [3:0] final_stat
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } run_state_t;

    run_state_t state_q, state_d;
    logic [3:0] flush_cnt;
    logic       lu, rt, mp;
    logic       m_exc, w_exc;

    assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_cnd;
    assign m_exc = (m_stat != S_AOK);
    assign w_exc = (W_stat != S_AOK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FLUSH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH:  if (flush_cnt == FLUSH_LAST) state_d = ST_RUN;
            // A faulting instruction already in writeback beats one still in memory
            ST_RUN:    if (w_exc) state_d = ST_HALTED;
                       else if (m_exc) state_d = ST_DRAIN;
            ST_DRAIN:  if (w_exc) state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_bubble = 1'b1;
            end
            ST_RUN, ST_DRAIN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (~lu & rt);
                E_bubble = mp | lu;
                M_bubble = (state_q == ST_DRAIN);
                set_cc   = (state_q == ST_RUN) && (E_icode == I_OPQ) && !m_exc && !w_exc;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
        endcase
    end

    assign state  = state_q;
    assign halted = (state_q == ST_HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt  <= 4'd0;
            final_stat <= S_AOK;
        end else begin
            flush_cnt <= (state_q == ST_FLUSH) ? flush_cnt + 4'd1 : 4'd0;
            if (state_q != ST_HALTED && state_d == ST_HALTED)
                final_stat <= W_stat;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic active;
    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (active) cycle_cnt <= cycle_cnt + 1'b1;
            if (active && F_stall) stall_cnt <= stall_cnt + 1'b1;
            if ((W_icode != I_NOP) && !w_exc && (state_q != ST_HALTED))
                retired_cnt <= retired_cnt + 1'b1;
        end
    end
`else
    logic unused_w_icode;
    assign unused_w_icode = ^W_icode;
`endif

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed bench for y86_pipe_ctrl: expected output vectors are queued with each stimulus step and popped on check.
module tb_y86_pipe_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat, W_icode;
    logic       e_cnd;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc;
    logic [1:0] state;
    logic       halted;
    logic [3:0] final_stat;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] cycle_cnt, retired_cnt, stall_cnt;
`endif

    y86_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble), .set_cc(set_cc),
        .state(state), .halted(halted), .final_stat(final_stat)
`ifdef PIPE_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ctl order: F_stall D_stall D_bubble E_bubble M_bubble W_stall W_bubble set_cc
    localparam logic [7:0] C_FLUSH = 8'b1011_1010;
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1101_0000;
    localparam logic [7:0] C_RT    = 8'b1010_0000;
    localparam logic [7:0] C_MPRT  = 8'b1011_0000;
    localparam logic [7:0] C_CC    = 8'b0000_0001;
    localparam logic [7:0] C_DRAIN = 8'b0000_1000;
    localparam logic [7:0] C_DRLU  = 8'b1101_1000;
    localparam logic [7:0] C_HALT  = 8'b1101_1100;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
        m_stat = 4'h1; W_stat = 4'h1;
    endtask

    task automatic set_lu();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] ctl, input logic [1:0] st, input logic [3:0] fs);
        exp_t e;
        e.tag = tag;
        e.val = {ctl, st, (st == 2'd3), fs};
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [14:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc,
                   state, halted, final_stat};
            checks++;
            assert (obs === e.val) passed++;
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input string tag, input logic [7:0] ctl, input logic [1:0] st, input logic [3:0] fs);
        push(tag, ctl, st, fs);
        chk();
    endtask

    task automatic cnt_chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Releases reset just after an edge and walks the two flush cycles into RUN.
    task automatic release_and_flush(input string tag);
        idle();
        reset = 1'b0;
        step({tag, "_fl1"}, C_FLUSH, 2'd0, 4'h1);
        cyc();
        step({tag, "_fl2"}, C_FLUSH, 2'd0, 4'h1);
        cyc();
        step({tag, "_run"}, C_NONE, 2'd1, 4'h1);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        step("rst_idle", C_FLUSH, 2'd0, 4'h1);
        set_lu(); D_icode = 4'h9;
        step("rst_haz", C_FLUSH, 2'd0, 4'h1);
        cyc();
        release_and_flush("boot");

        // load-use
        set_lu();
        step("lu_srcB", C_LU, 2'd1, 4'h1);
        E_dstM = 4'hF;
        step("lu_none", C_NONE, 2'd1, 4'h1);
        idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
        step("lu_popq", C_LU, 2'd1, 4'h1);

        // ret travelling D -> E -> M
        idle(); D_icode = 4'h9;
        cyc(); step("ret_D", C_RT, 2'd1, 4'h1);
        idle(); E_icode = 4'h9;
        cyc(); step("ret_E", C_RT, 2'd1, 4'h1);
        idle(); M_icode = 4'h9;
        cyc(); step("ret_M", C_RT, 2'd1, 4'h1);
        set_lu();
        step("lu_ret", C_LU, 2'd1, 4'h1);

        // mispredict
        idle(); E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
        cyc(); step("mp_ret", C_MPRT, 2'd1, 4'h1);
        D_icode = 4'h1; e_cnd = 1'b1;
        step("jxx_taken", C_NONE, 2'd1, 4'h1);

        // cc gating, drain, halt
        idle(); E_icode = 4'h6;
        cyc(); step("set_cc", C_CC, 2'd1, 4'h1);
        m_stat = 4'h3;
        step("cc_m_exc", C_NONE, 2'd1, 4'h1);
        cyc(); step("drain", C_DRAIN, 2'd2, 4'h1);
        set_lu();
        step("drain_lu", C_DRLU, 2'd2, 4'h1);
        idle(); m_stat = 4'h3; W_stat = 4'h3;
        step("drain_w", C_DRAIN, 2'd2, 4'h1);
        cyc(); step("halted", C_HALT, 2'd3, 4'h3);
        idle(); set_lu();
        cyc(); step("halt_hold", C_HALT, 2'd3, 4'h3);
        W_stat = 4'h4;
        cyc(); step("halt_sticky", C_HALT, 2'd3, 4'h3);

        // reset from HALTED, then reset in the middle of a drain
        reset = 1'b1;
        step("rst_halt", C_FLUSH, 2'd0, 4'h1);
        cyc();
        release_and_flush("r2");
        m_stat = 4'h2;
        cyc(); step("drain2", C_DRAIN, 2'd2, 4'h1);
        reset = 1'b1;
        step("rst_drain", C_FLUSH, 2'd0, 4'h1);
        cyc();
        release_and_flush("r3");

        // writeback exception wins over memory exception
        m_stat = 4'h3; W_stat = 4'h4;
        step("short_pre", C_NONE, 2'd1, 4'h1);
        cyc(); step("short_halt", C_HALT, 2'd3, 4'h4);

`ifdef PIPE_PERF_CNT_EN
        reset = 1'b1;
        cyc();
        release_and_flush("perf");
        cnt_chk("cyc_start", cycle_cnt, 4'd0);
        repeat (17) cyc();
        cnt_chk("cyc_wrap", cycle_cnt, 4'd1);
        cnt_chk("ret_zero", retired_cnt, 4'd0);
        cnt_chk("stall_zero", stall_cnt, 4'd0);
        W_icode = 4'h6;
        repeat (3) cyc();
        cnt_chk("retired3", retired_cnt, 4'd3);
        W_icode = 4'h1;
        set_lu();
        repeat (2) cyc();
        cnt_chk("stall2", stall_cnt, 4'd2);
        cnt_chk("cyc6", cycle_cnt, 4'd6);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
